mem_stage: RTL and testbench

Memory-access stage of the multi-cycle core. It sits directly downstream of the ALU. In the stage after execute, it takes the ALU result (effective address or plain result) and the pass-through operand (store data). Loads and stores run a req/ack transaction on the data-memory port; loads are sign- or zero-extended. Every instruction yields a write-back value and a one-cycle completion pulse for the control unit.

---
 rtl/mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: runs load/store req/ack transactions; non-memory ops pass the ALU result through.
// Latency: 1 cycle for non-memory/misaligned/illegal ops, 2+k cycles for memory ops with k wait cycles.
// Backpressure: waits in ACCESS for dmem_ack_i up to TIMEOUT_CYCLES request cycles, then faults.
module mem_stage #(
    parameter int MEM_STAGE      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic [4:0]  itype_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] wb_data_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        misalign_o,
    output logic        fault_o
);

    // Shared one-hot instruction-class encodings; only loads and stores act here.
    localparam logic [4:0] ITYPE_LTYPE = 5'b00100;
    localparam logic [4:0] ITYPE_STYPE = 5'b01000;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  prev_stage;
    logic [7:0]  cnt, cnt_nxt;
    logic [1:0]  a_lo, a_lo_nxt;
    logic [2:0]  f3_q, f3_nxt;
    logic        st_q, st_nxt;

    logic        req_nxt, we_nxt, done_nxt, busy_nxt, mis_nxt, fault_nxt;
    logic [31:0] addr_nxt, wdata_nxt, wb_nxt;
    logic [3:0]  be_nxt;

    logic        trigger, is_ld, is_st, illegal, misaligned;

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    load_ext = {{24{b[7]}}, b};
            3'd4:    load_ext = {24'b0, b};
            3'd1:    load_ext = {{16{h[15]}}, h};
            3'd5:    load_ext = {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Rising edge into the memory stage, decoded from the raw inputs.
    always_comb begin
        trigger    = (stage_i == 3'(MEM_STAGE)) && (prev_stage != 3'(MEM_STAGE));
        is_ld      = (itype_i == ITYPE_LTYPE);
        is_st      = (itype_i == ITYPE_STYPE);
        illegal    = (is_ld && (funct3_i == 3'd3 || funct3_i == 3'd6 || funct3_i == 3'd7))
                   || (is_st && (funct3_i > 3'd2));
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0])
                   || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and next registered-output values; the request side holds its values
    // unless a new access starts, and status flags default low so they clear after DONE.
    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        mis_nxt   = 1'b0;
        fault_nxt = 1'b0;
        we_nxt    = dmem_we_o;
        addr_nxt  = dmem_addr_o;
        be_nxt    = dmem_be_o;
        wdata_nxt = dmem_wdata_o;
        wb_nxt    = wb_data_o;
        cnt_nxt   = cnt;
        a_lo_nxt  = a_lo;
        f3_nxt    = f3_q;
        st_nxt    = st_q;
        case (state)
            IDLE: begin
                if (trigger) begin
                    if (!(is_ld || is_st)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        wb_nxt    = addr_i;
                    end else if (illegal) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        fault_nxt = 1'b1;
                        wb_nxt    = 32'b0;
                    end else if (misaligned) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        mis_nxt   = 1'b1;
                        wb_nxt    = 32'b0;
                    end else begin
                        state_nxt = ACCESS;
                        req_nxt   = 1'b1;
                        busy_nxt  = 1'b1;
                        we_nxt    = is_st;
                        addr_nxt  = {addr_i[31:2], 2'b00};
                        cnt_nxt   = 8'd0;
                        a_lo_nxt  = addr_i[1:0];
                        f3_nxt    = funct3_i;
                        st_nxt    = is_st;
                        be_nxt    = 4'b1111;
                        wdata_nxt = wdata_i;
                        if (is_st) begin
                            case (funct3_i[1:0])
                                2'd0: begin
                                    be_nxt    = 4'b0001 << addr_i[1:0];
                                    wdata_nxt = {4{wdata_i[7:0]}};
                                end
                                2'd1: begin
                                    be_nxt    = addr_i[1] ? 4'b1100 : 4'b0011;
                                    wdata_nxt = {2{wdata_i[15:0]}};
                                end
                                default: begin
                                    be_nxt    = 4'b1111;
                                    wdata_nxt = wdata_i;
                                end
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    wb_nxt    = st_q ? 32'b0 : load_ext(dmem_rdata_i, a_lo, f3_q);
                end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    fault_nxt = 1'b1;
                    wb_nxt    = 32'b0;
                    cnt_nxt   = 8'd0;
                end else begin
                    req_nxt   = 1'b1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs and latched transaction context.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_stage   <= 3'd0;
            cnt          <= 8'd0;
            a_lo         <= 2'd0;
            f3_q         <= 3'd0;
            st_q         <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'b0;
            dmem_be_o    <= 4'b0;
            dmem_wdata_o <= 32'b0;
            wb_data_o    <= 32'b0;
            done_o       <= 1'b0;
            busy_o       <= 1'b0;
            misalign_o   <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            prev_stage   <= stage_i;
            cnt          <= cnt_nxt;
            a_lo         <= a_lo_nxt;
            f3_q         <= f3_nxt;
            st_q         <= st_nxt;
            dmem_req_o   <= req_nxt;
            dmem_we_o    <= we_nxt;
            dmem_addr_o  <= addr_nxt;
            dmem_be_o    <= be_nxt;
            dmem_wdata_o <= wdata_nxt;
            wb_data_o    <= wb_nxt;
            done_o       <= done_nxt;
            busy_o       <= busy_nxt;
            misalign_o   <= mis_nxt;
            fault_o      <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected completions.
// Completion latency is checked against the cycle each transaction is expected to finish.
// A simple memory responder acks after a programmable number of request cycles.
module tb_mem_stage;

    localparam logic [4:0] RTYPE = 5'b00001;
    localparam logic [4:0] ITYPE = 5'b00010;
    localparam logic [4:0] LTYPE = 5'b00100;
    localparam logic [4:0] STYPE = 5'b01000;
    localparam logic [2:0] MEM   = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  stage_i = 3'd0;
    logic [4:0]  itype_i = 5'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    wire         dmem_ack_i;
    wire  [31:0] dmem_rdata_i;
    logic [31:0] wb_data_o;
    logic        done_o, busy_o, misalign_o, fault_o;

    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    assign dmem_ack_i   = resp_ack | force_ack;
    assign dmem_rdata_i = mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_delay = -1;
    int wait_cnt = 0;
    int req_cycles = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_we;
    logic [3:0]  exp_be;

    typedef struct {
        logic [31:0] wb;
        logic        mis;
        logic        flt;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    mem_stage #(.MEM_STAGE(4), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .stage_i(stage_i), .itype_i(itype_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_data_o(wb_data_o), .done_o(done_o),
        .busy_o(busy_o), .misalign_o(misalign_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: acks on the (ack_delay+1)-th request cycle and checks request fields.
    always @(negedge clk) begin
        if (dmem_req_o) begin
            req_cycles++;
            if (ack_delay >= 0 && wait_cnt == ack_delay) begin
                resp_ack = 1'b1;
                wait_cnt = 0;
                chk("req_addr", dmem_addr_o, exp_addr);
                chk("req_we", 32'(dmem_we_o), 32'(exp_we));
                chk("req_be", 32'(dmem_be_o), 32'(exp_be));
                if (exp_we) chk("req_wdata", dmem_wdata_o, exp_wdata);
            end else begin
                resp_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no completion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_data", wb_data_o, e.wb);
                chk("misalign", 32'(misalign_o), 32'(e.mis));
                chk("fault", 32'(fault_o), 32'(e.flt));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic run(input logic [4:0] it, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int k,
                       input logic [31:0] ewb, input logic emis, input logic eflt,
                       input int lat, input logic ewe, input logic [3:0] ebe,
                       input logic [31:0] ewd, input int hold, input int ereq);
        @(negedge clk);
        itype_i    = it;
        funct3_i   = f3;
        addr_i     = a;
        wdata_i    = wd;
        mem_rdata  = rd;
        ack_delay  = k;
        exp_addr   = {a[31:2], 2'b00};
        exp_we     = ewe;
        exp_be     = ebe;
        exp_wdata  = ewd;
        req_cycles = 0;
        sb.push_back('{ewb, emis, eflt, cyc + lat});
        stage_i    = MEM;
        repeat (hold) @(negedge clk);
        stage_i    = 3'd0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_wait: got no done_o within budget expected completion");
            sb.delete();
        end
        repeat (2) @(negedge clk);
        chk("req_cycles", 32'(req_cycles), 32'(ereq));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wb", wb_data_o, 32'd0);
        chk("rst_flags", {30'd0, misalign_o, fault_o}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // it, f3, addr, wdata, rdata, k, wb, mis, flt, lat, we, be, wdata, hold, req
        run(RTYPE, 3'd0, 32'h0000_1234, 32'h0, 32'h0, -1, 32'h0000_1234, 0, 0, 1, 0, 4'h0, 32'h0, 1, 0);
        run(LTYPE, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3, 32'hFFFF_FF80, 0, 0, 5, 0, 4'hF, 32'h0, 1, 4);
        run(LTYPE, 3'd4, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3, 32'h0000_0080, 0, 0, 5, 0, 4'hF, 32'h0, 1, 4);
        run(STYPE, 3'd1, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 32'h0, 0, 0, 2, 1, 4'b1100, 32'hABCD_ABCD, 1, 1);
        run(LTYPE, 3'd2, 32'h0000_0301, 32'h0, 32'h0, 0, 32'h0, 1, 0, 1, 0, 4'h0, 32'h0, 1, 0);
        run(LTYPE, 3'd1, 32'h0000_0106, 32'h0, 32'h8001_0000, 1, 32'hFFFF_8001, 0, 0, 3, 0, 4'hF, 32'h0, 1, 2);
        run(LTYPE, 3'd5, 32'h0000_0102, 32'h0, 32'h7FFF_1234, 0, 32'h0000_7FFF, 0, 0, 2, 0, 4'hF, 32'h0, 1, 1);
        run(STYPE, 3'd0, 32'h0000_0041, 32'h1234_565A, 32'h0, 1, 32'h0, 0, 0, 3, 1, 4'b0010, 32'h5A5A_5A5A, 1, 2);
        run(STYPE, 3'd2, 32'h0000_0044, 32'hCAFE_F00D, 32'h0, 2, 32'h0, 0, 0, 4, 1, 4'hF, 32'hCAFE_F00D, 1, 3);
        run(LTYPE, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 0, 32'h0, 0, 1, 1, 0, 4'h0, 32'h0, 1, 0);
        run(STYPE, 3'd4, 32'h0000_0100, 32'h0, 32'h0, 0, 32'h0, 0, 1, 1, 0, 4'h0, 32'h0, 1, 0);
        // Stage held in MEM for several cycles must produce only one completion.
        run(ITYPE, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, -1, 32'hDEAD_BEEF, 0, 0, 1, 0, 4'h0, 32'h0, 6, 0);
        // Timeout with no ack, then a late ack in IDLE must be ignored.
        run(LTYPE, 3'd2, 32'h0000_0500, 32'h0, 32'h0, -1, 32'h0, 0, 1, 5, 0, 4'hF, 32'h0, 1, 4);
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_done", 32'(done_o), 32'd0);
            chk("late_ack_req", 32'(dmem_req_o), 32'd0);
        end
        force_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the second ACCESS cycle.
        @(negedge clk);
        itype_i   = LTYPE;
        funct3_i  = 3'd2;
        addr_i    = 32'h0000_0600;
        ack_delay = -1;
        stage_i   = MEM;
        @(negedge clk);
        chk("pre_rst_req", 32'(dmem_req_o), 32'd1);
        stage_i = 3'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_req", 32'(dmem_req_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_addr", dmem_addr_o, 32'd0);
        chk("mid_rst_be", 32'(dmem_be_o), 32'd0);
        repeat (3) @(negedge clk);
        run(LTYPE, 3'd2, 32'h0000_0400, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 0, 0, 3, 0, 4'hF, 32'h0, 1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $fatal(1, "global timeout");
    end

endmodule
